// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline control logic.
package mips_pkg;

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    MEM_WAIT
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: the load in ID_EXE writes a register that the ID instruction reads.
module load_use_detect
  import mips_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  input  logic       id_exe_mem_read_i,
  input  logic [4:0] id_exe_rt_i,
  output logic       hz_o
);

  // $zero is never a real dependency, so a load targeting it cannot cause a stall.
  assign hz_o = id_exe_mem_read_i && (id_exe_rt_i != REG_ZERO) &&
                ((id_exe_rt_i == id_rs_i) || (id_uses_rt_i && (id_exe_rt_i == id_rt_i)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, branch flushes, memory-busy freeze, event counters.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_exe_mem_read,
  input  logic [4:0]       id_exe_rt,
  input  logic             exe_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_exe_write,
  output logic             id_exe_bubble,
  output logic             exe_mem_write,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] StallInit = 3'(LOAD_STALL_CYCLES - 1);

  hz_state_t        state_q, state_d;
  hz_state_t        ret_state_q, ret_state_d;
  hz_state_t        eff_state;
  logic [2:0]       stall_left_q, stall_left_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hz;

  load_use_detect u_load_use_detect (
    .id_rs_i          (id_rs),
    .id_rt_i          (id_rt),
    .id_uses_rt_i     (id_uses_rt),
    .id_exe_mem_read_i(id_exe_mem_read),
    .id_exe_rt_i      (id_exe_rt),
    .hz_o             (hz)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RUN;
      ret_state_q  <= RUN;
      stall_left_q <= 3'd0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      ret_state_q  <= ret_state_d;
      stall_left_q <= stall_left_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_write  = 1'b1;
    id_exe_bubble = 1'b0;
    exe_mem_write = 1'b1;
    state_d       = state_q;
    ret_state_d   = ret_state_q;
    stall_left_d  = stall_left_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    // Leaving MEM_WAIT, the cycle behaves as the state that was frozen.
    eff_state     = (state_q == MEM_WAIT) ? ret_state_q : state_q;

    if (!rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_exe_bubble = 1'b1;
      state_d       = RUN;
      ret_state_d   = RUN;
      stall_left_d  = 3'd0;
      stall_cnt_d   = '0;
      flush_cnt_d   = '0;
    end else if (mem_busy) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_exe_write  = 1'b0;
      exe_mem_write = 1'b0;
      if (state_q != MEM_WAIT) ret_state_d = state_q;
      state_d = MEM_WAIT;
    end else if (exe_branch_taken) begin
      if_id_flush   = 1'b1;
      id_exe_bubble = 1'b1;
      stall_left_d  = 3'd0;
      state_d       = RUN;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if ((eff_state == LOAD_STALL) || ((eff_state == RUN) && hz)) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_exe_bubble = 1'b1;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (eff_state == LOAD_STALL) begin
        if (stall_left_q <= 3'd1) begin
          stall_left_d = 3'd0;
          state_d      = RUN;
        end else begin
          stall_left_d = stall_left_q - 3'd1;
          state_d      = LOAD_STALL;
        end
      end else if (LOAD_STALL_CYCLES > 1) begin
        stall_left_d = StallInit;
        state_d      = LOAD_STALL;
      end else begin
        state_d = RUN;
      end
    end else begin
      state_d = RUN;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
